// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i memory arbiter: the core's MemWrite encoding,
// the arbiter state and the owner of the outstanding access.
package rv32i_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_B    = 2'b01,
        SZ_H    = 2'b10,
        SZ_W    = 2'b11
    } storeSize_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_REQ  = 2'b01,
        ARB_RESP = 2'b10
    } arbState_t;

    typedef enum logic [1:0] {
        OWN_FETCH = 2'b00,
        OWN_LOAD  = 2'b01,
        OWN_STORE = 2'b10
    } owner_t;

endpackage

// File: rtl/rv32i_lane_gen.sv
// Byte-lane enables, lane-replicated write data and alignment check for one
// data access. Loads arrive here as SZ_W so they get full lanes and word alignment.
module rv32i_lane_gen
    import rv32i_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addrLo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] laneWdata,
    output logic        misalign
);

    always_comb begin
        be        = 4'b1111;
        laneWdata = wdata;
        misalign  = 1'b0;
        unique case (storeSize_t'(size))
            SZ_B: begin
                be        = 4'b0001 << addrLo;
                laneWdata = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be        = 4'b0011 << addrLo;
                laneWdata = {2{wdata[15:0]}};
                misalign  = addrLo[0];
            end
            SZ_W: begin
                misalign  = (addrLo != 2'b00);
            end
            default: begin
                be        = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// one access outstanding, data priority with a bounded streak so fetch cannot starve.
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ready,
    input  logic              d_rd,
    input  logic [1:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              d_misalign,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    arbState_t           state;
    owner_t              owner;
    logic [STREAK_W-1:0] streak;

    logic        dIsStore;
    logic        dWants;
    logic [1:0]  laneSize;
    logic [3:0]  laneBe;
    logic [31:0] laneWdata;
    logic        laneMisalign;
    logic        forceFetch;
    logic        grantData;
    logic        grantFetch;
    logic        complete;
    logic        arbNow;
    logic        unusedFetchLo;

    // Fetch addresses are word aligned by construction; low bits are dropped.
    assign unusedFetchLo = ^i_addr[1:0];

    assign dIsStore = (d_we != SZ_NONE);
    assign dWants   = d_rd | dIsStore;
    assign laneSize = dIsStore ? d_we : SZ_W;

    rv32i_lane_gen u_laneGen (
        .size      (laneSize),
        .addrLo    (d_addr[1:0]),
        .wdata     (d_wdata),
        .be        (laneBe),
        .laneWdata (laneWdata),
        .misalign  (laneMisalign)
    );

    assign forceFetch = i_req && (streak == STREAK_W'(MAX_D_STREAK));
    assign grantData  = dWants && !forceFetch;
    assign grantFetch = i_req && !grantData;

    // A same-cycle gnt+rvalid in REQ completes exactly like rvalid in RESP.
    assign complete = ((state == ARB_REQ) && mem_gnt && mem_rvalid) ||
                      ((state == ARB_RESP) && mem_rvalid);
    assign arbNow   = (state == ARB_IDLE) || complete;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            owner      <= OWN_FETCH;
            streak     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            d_misalign <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            d_misalign <= 1'b0;
            if (!i_req) begin
                streak <= '0;
            end

            if (complete) begin
                if (owner == OWN_FETCH) begin
                    i_ready <= 1'b1;
                    i_rdata <= mem_rdata;
                end else begin
                    d_ready <= 1'b1;
                    if (owner == OWN_LOAD) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end

            if ((state == ARB_REQ) && mem_gnt && !mem_rvalid) begin
                mem_req <= 1'b0;
                state   <= ARB_RESP;
            end

            if (arbNow) begin
                mem_req <= 1'b0;
                state   <= ARB_IDLE;
                if (grantData) begin
                    if (i_req) begin
                        streak <= streak + 1'b1;
                    end
                    if (laneMisalign) begin
                        d_misalign <= 1'b1;
                        d_ready    <= 1'b1;
                    end else begin
                        mem_req   <= 1'b1;
                        state     <= ARB_REQ;
                        mem_we    <= dIsStore;
                        mem_be    <= laneBe;
                        mem_wdata <= laneWdata;
                        mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                        owner     <= dIsStore ? OWN_STORE : OWN_LOAD;
                    end
                end else if (grantFetch) begin
                    streak    <= '0;
                    mem_req   <= 1'b1;
                    state     <= ARB_REQ;
                    mem_we    <= 1'b0;
                    mem_be    <= 4'b1111;
                    mem_wdata <= '0;
                    mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                    owner     <= OWN_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter: expected memory accesses and ready
// strobes are queued when stimulus is driven and checked as the DUT produces them.
module tb_rv32i_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_rd;
    logic [1:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_misalign;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        autoMem;
    logic        manGnt;
    logic        manRvalid;
    logic [31:0] manRdata;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        int          port;   // 0 fetch, 1 data, 2 data misaligned
        logic [31:0] data;
    } rdy_t;

    acc_t        expAcc[$];
    rdy_t        expRdy[$];
    acc_t        a;
    rdy_t        r;
    int          gotPort;
    logic [31:0] modelD;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] ad);
        if (ad == 32'h100) return 32'h0050_0093;
        return ad ^ 32'h5A5A_0000;
    endfunction

    assign mem_gnt    = autoMem ? mem_req : manGnt;
    assign mem_rvalid = autoMem ? mem_req : manRvalid;
    assign mem_rdata  = autoMem ? memWord(mem_addr) : manRdata;

    rv32i_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .d_rd       (d_rd),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .d_misalign (d_misalign),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // Monitor: accepted memory accesses and ready strobes against the queues.
    always @(negedge clk) begin
        if (mem_req && mem_gnt) begin
            checks++;
            if (expAcc.size() == 0) begin
                errors++;
                $display("FAIL acc_unexpected: got we=%b be=%b addr=%h, required no access",
                         mem_we, mem_be, mem_addr);
            end else begin
                a = expAcc.pop_front();
                if (mem_we !== a.we || mem_be !== a.be || mem_addr !== a.addr ||
                    (a.we && mem_wdata !== a.wdata)) begin
                    errors++;
                    $display("FAIL acc: got we=%b be=%b addr=%h wdata=%h, required we=%b be=%b addr=%h wdata=%h",
                             mem_we, mem_be, mem_addr, mem_wdata, a.we, a.be, a.addr, a.wdata);
                end
            end
        end
        if (i_ready || d_ready || d_misalign) begin
            checks++;
            gotPort = i_ready ? (d_ready ? 9 : 0) : (d_ready ? (d_misalign ? 2 : 1) : 3);
            if (expRdy.size() == 0) begin
                errors++;
                $display("FAIL rdy_unexpected: got port=%0d, required no ready", gotPort);
            end else begin
                r = expRdy.pop_front();
                if (gotPort != r.port) begin
                    errors++;
                    $display("FAIL rdy_port: got port=%0d, required port=%0d", gotPort, r.port);
                end else if (r.port == 0 && i_rdata !== r.data) begin
                    errors++;
                    $display("FAIL i_rdata: got %h, required %h", i_rdata, r.data);
                end else if (r.port != 0 && d_rdata !== r.data) begin
                    errors++;
                    $display("FAIL d_rdata: got %h, required %h", d_rdata, r.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound, input string name);
        for (int i = 0; i < bound && (expAcc.size() != 0 || expRdy.size() != 0); i++) tick();
        checks++;
        if (expAcc.size() != 0 || expRdy.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got acc=%0d rdy=%0d pending, required 0",
                     name, expAcc.size(), expRdy.size());
            expAcc.delete();
            expRdy.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({mem_req, i_ready, d_ready, d_misalign} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b, required 0000", {mem_req, i_ready, d_ready, d_misalign});
        end
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got i=%h d=%h, required 0", i_rdata, d_rdata);
        end
        rst = 1'b1;
        modelD = 32'h0;
        tick();
    endtask

    task automatic test_fetch_only();
        i_req = 1'b1;
        i_addr = 32'h100;
        expAcc.push_back('{1'b0, 4'hF, 32'h100, 32'h0});
        expRdy.push_back('{0, 32'h0050_0093});
        tick();
        i_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch_req: got req=%b addr=%h we=%b, required 1 00000100 0", mem_req, mem_addr, mem_we);
        end
        tick();
        checks++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h0050_0093) begin
            errors++;
            $display("FAIL fetch_ready: got ready=%b rdata=%h, required 1 00500093", i_ready, i_rdata);
        end
        tick();
        checks++;
        if (i_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_strobe_len: got %b, required 0", i_ready);
        end
        drain(10, "fetch");
    endtask

    task automatic test_store_byte();
        d_we = 2'b01;
        d_addr = 32'h203;
        d_wdata = 32'h0000_00AB;
        expAcc.push_back('{1'b1, 4'b1000, 32'h200, 32'hABAB_ABAB});
        expRdy.push_back('{1, modelD});
        tick();
        d_we = 2'b00;
        drain(10, "store_byte");
        tick();
        tick();
    endtask

    task automatic test_contention();
        int n = 0;
        for (int g = 0; g < 10; g++) begin
            if (g == 4 || g == 9) begin
                expAcc.push_back('{1'b0, 4'hF, 32'h300, 32'h0});
                expRdy.push_back('{0, memWord(32'h300)});
            end else begin
                expAcc.push_back('{1'b0, 4'hF, 32'h400, 32'h0});
                expRdy.push_back('{1, memWord(32'h400)});
            end
        end
        modelD = memWord(32'h400);
        i_req = 1'b1;
        i_addr = 32'h300;
        d_rd = 1'b1;
        d_addr = 32'h400;
        for (int c = 0; c < 40 && n < 10; c++) begin
            tick();
            if (mem_req) n++;
        end
        i_req = 1'b0;
        d_rd = 1'b0;
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL contention_grants: got %0d, required 10", n);
        end
        drain(20, "contention");
    endtask

    task automatic test_misaligned();
        d_we = 2'b11;
        d_addr = 32'h202;
        d_wdata = 32'h1234_5678;
        expRdy.push_back('{2, modelD});
        tick();
        d_we = 2'b00;
        checks++;
        if (mem_req !== 1'b0 || d_misalign !== 1'b1 || d_ready !== 1'b1) begin
            errors++;
            $display("FAIL misalign_word: got req=%b mis=%b rdy=%b, required 0 1 1", mem_req, d_misalign, d_ready);
        end
        tick();
        checks++;
        if (d_misalign !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_after: got mis=%b req=%b, required 0 0", d_misalign, mem_req);
        end
        d_we = 2'b10;
        d_addr = 32'h202;
        d_wdata = 32'h0000_1234;
        expAcc.push_back('{1'b1, 4'b1100, 32'h200, 32'h1234_1234});
        expRdy.push_back('{1, modelD});
        tick();
        d_we = 2'b00;
        drain(10, "half_store");
    endtask

    task automatic test_backpressure();
        autoMem = 1'b0;
        manGnt = 1'b0;
        manRvalid = 1'b0;
        d_we = 2'b11;
        d_addr = 32'h500;
        d_wdata = 32'hDEAD_BEEF;
        expAcc.push_back('{1'b1, 4'hF, 32'h500, 32'hDEAD_BEEF});
        expRdy.push_back('{1, modelD});
        tick();
        d_we = 2'b00;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h500 || mem_be !== 4'hF ||
                mem_wdata !== 32'hDEAD_BEEF || d_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got req=%b addr=%h be=%b wdata=%h rdy=%b, required 1 00000500 1111 deadbeef 0",
                         k, mem_req, mem_addr, mem_be, mem_wdata, d_ready);
            end
            manRvalid = (k == 2);
            tick();
        end
        manRvalid = 1'b0;
        manGnt = 1'b1;
        tick();
        manGnt = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL resp_wait: got req=%b rdy=%b, required 0 0", mem_req, d_ready);
        end
        tick();
        manRvalid = 1'b1;
        manRdata = 32'hFFFF_FFFF;
        tick();
        manRvalid = 1'b0;
        checks++;
        if (d_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp_ready: got %b, required 1", d_ready);
        end
        i_req = 1'b1;
        i_addr = 32'h104;
        expAcc.push_back('{1'b0, 4'hF, 32'h104, 32'h0});
        expRdy.push_back('{0, 32'h1122_3344});
        tick();
        i_req = 1'b0;
        manGnt = 1'b1;
        manRvalid = 1'b1;
        manRdata = 32'h1122_3344;
        tick();
        manGnt = 1'b0;
        manRvalid = 1'b0;
        checks++;
        if (i_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle: got ready=%b req=%b, required 1 0", i_ready, mem_req);
        end
        drain(10, "backpressure");
    endtask

    task automatic test_reset_in_resp();
        i_req = 1'b1;
        i_addr = 32'h108;
        expAcc.push_back('{1'b0, 4'hF, 32'h108, 32'h0});
        tick();
        i_req = 1'b0;
        manGnt = 1'b1;
        tick();
        manGnt = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        modelD = 32'h0;
        checks++;
        if ({mem_req, i_ready, d_ready, d_misalign} !== 4'b0000 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL resp_reset: got strobes=%b i=%h d=%h, required 0000 0 0",
                     {mem_req, i_ready, d_ready, d_misalign}, i_rdata, d_rdata);
        end
        manRvalid = 1'b1;
        manRdata = 32'hBAD0_BAD0;
        tick();
        manRvalid = 1'b0;
        tick();
        checks++;
        if (i_ready !== 1'b0 || d_ready !== 1'b0 || i_rdata !== 32'h0) begin
            errors++;
            $display("FAIL stale_rvalid: got i_ready=%b d_ready=%b i_rdata=%h, required 0 0 0",
                     i_ready, d_ready, i_rdata);
        end
        autoMem = 1'b1;
        i_req = 1'b1;
        i_addr = 32'h100;
        expAcc.push_back('{1'b0, 4'hF, 32'h100, 32'h0});
        expRdy.push_back('{0, 32'h0050_0093});
        tick();
        i_req = 1'b0;
        drain(20, "after_reset");
    endtask

    initial begin
        rst = 1'b0;
        i_req = 1'b0;
        i_addr = 32'h0;
        d_rd = 1'b0;
        d_we = 2'b00;
        d_addr = 32'h0;
        d_wdata = 32'h0;
        autoMem = 1'b1;
        manGnt = 1'b0;
        manRvalid = 1'b0;
        manRdata = 32'h0;
        modelD = 32'h0;

        test_reset();
        test_fetch_only();
        test_store_byte();
        test_contention();
        test_misaligned();
        test_backpressure();
        test_reset_in_resp();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipelined core's instruction-fetch port and its data-memory port.
- Sits between the core top level (PCF/InstrF, ALUResultM/WriteDataM/MemWrite/ReadDataMTick) and the external memory.
- Turns the core's byte/half/word stores into byte-lane strobes and grants one access at a time.
- Returns per-port ready strobes that the hazard logic uses as stalls.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive data grants while a fetch is pending before fetch is forced.
- ADDR_W, 32: address width on both core ports and the memory port.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request, held until i_ready
- i_addr  in  ADDR_W  fetch address (PCF); must be word aligned
- i_rdata  out  32  fetched instruction (InstrF)
- i_ready  out  1  one-cycle strobe: i_rdata valid, request retired
- d_rd  in  1  load request, held until d_ready
- d_we  in  2  store size (MemWrite): 00 none, 01 byte, 10 half, 11 word
- d_addr  in  ADDR_W  data address (ALUResultM)
- d_wdata  in  32  store data, low-aligned (WriteDataM)
- d_rdata  out  32  raw load word (ReadDataMTick); extension is done in the core
- d_ready  out  1  one-cycle strobe: data access complete
- d_misalign  out  1  one-cycle strobe: data access rejected as misaligned
- mem_req  out  1  memory request valid
- mem_gnt  in  1  memory accepts the request this cycle
- mem_we  out  1  write enable
- mem_be  out  4  byte-lane enables
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 00
- mem_wdata  out  32  lane-replicated write data
- mem_rvalid  in  1  response valid; carries read data or write completion
- mem_rdata  in  32  read data

Behaviour:
- Reset (rst=0 at clk edge):
  - State goes to IDLE and the streak counter to 0.
  - mem_req, i_ready, d_ready and d_misalign are 0; i_rdata and d_rdata are 0.
  - Reset during an outstanding access abandons it; any later mem_rvalid for it is ignored while in IDLE.
- FSM states:
  - IDLE: no access outstanding.
  - REQ: mem_req high, waiting for mem_gnt.
  - RESP: waiting for mem_rvalid.
- Exactly one access is outstanding at a time.
- Arbitration in IDLE, and in the RESP cycle where mem_rvalid=1, so back-to-back grants are possible:
  - A data request (d_rd=1 or d_we!=00) wins, unless i_req=1 and the streak counter equals MAX_D_STREAK; then fetch wins.
  - Streak counter: increments on each data grant while i_req=1; clears on any fetch grant or when i_req=0.
  - Only fetch pending: fetch granted.
  - d_rd and d_we!=00 together: treated as a store.
- Misaligned data request (checked before grant):
  - half with addr[0]=1, word or load with addr[1:0]!=00 (loads are issued as word reads).
  - No memory access. d_misalign=1 and d_ready=1 in the next cycle. Counts as a data grant.
- Lane generation:
  - byte: mem_be = 0001 << addr[1:0]; mem_wdata = d_wdata[7:0] replicated 4x.
  - half: mem_be = 0011 << addr[1:0]; mem_wdata = d_wdata[15:0] replicated 2x.
  - word: mem_be = 1111; mem_wdata = d_wdata.
  - load or fetch: mem_be = 1111, mem_we = 0.
- The selected address, strobes and data are registered on grant. They are held stable on the mem_* outputs for the whole of REQ.
- mem_req rises the cycle after grant. REQ goes to RESP on mem_gnt.
- If mem_gnt and mem_rvalid arrive in the same cycle: the access completes that cycle; RESP is skipped.
- On mem_rvalid, the owning port gets a ready strobe of exactly one cycle.
  - Fetch: i_rdata <= mem_rdata.
  - Load: d_rdata <= mem_rdata.
  - Store: d_rdata unchanged.
- Rdata registers hold their value until the next completion on that port.
- Minimum latency with mem_gnt=1 and mem_rvalid=1 on the cycle after mem_req: request cycle 0, mem_req cycle 1, ready cycle 2.
- A requester that drops its request before ready (fetch flush) is still completed internally; the ready strobe is then ignored by the core.
- mem_rvalid in IDLE or REQ (before mem_gnt) is ignored.

Decomposition:
- Shared package rv32i_pkg:
  - store-size enum (SZ_NONE, SZ_B, SZ_H, SZ_W) matching the core's MemWrite encoding.
  - arbiter state enum (ARB_IDLE, ARB_REQ, ARB_RESP).
- One combinational sub-module, rv32i_lane_gen: inputs size + addr[1:0] + wdata; outputs be, wdata and misalign. The FSM and arbitration stay in the top.

Test Plan:
1. Fetch only: i_req=1, i_addr=0x100, memory returns 0x00500093 with 1-cycle gnt/rvalid -> mem_addr=0x100, mem_we=0, i_ready pulses 2 cycles after the request with i_rdata=0x00500093.
2. Store byte: d_we=01, d_addr=0x203, d_wdata=0x000000AB -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x200, d_ready pulses once, i_ready does not.
3. Contention and streak: i_req and data requests held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; counter clears after each fetch grant.
4. Misaligned: d_we=11, d_addr=0x202 -> mem_req stays 0, d_misalign=1 and d_ready=1 next cycle. Half store at 0x202 -> mem_be=1100, no misalign.
5. Memory backpressure: mem_gnt held 0 for 5 cycles -> mem_addr, mem_be and mem_wdata stable throughout. Same-cycle gnt+rvalid -> ready next cycle, no RESP state.
6. Reset in RESP: rst=0 for one cycle, then a stale mem_rvalid arrives -> no ready strobe, outputs zero, next i_req serviced normally.
